conv3_sched: RTL and testbench
==============================

Name: conv3_sched

Overview:
- Sequencer for the 3x3 sliding-window line buffer (conv3 datapath) and its input feature-map SRAM.
- On a start command it streams each channel's WIDTH*HEIGHT pixels from SRAM into the line buffer.
- It counts the windows the buffer emits, clears the buffer between channels and signals completion to the layer controller.
- Sits between the layer controller (start/done), the SRAM read port, and the line buffer/MAC array.

Parameters:
- WIDTH, 8, feature-map width in pixels
- HEIGHT, 10, feature-map height in pixels
- DATA_BITS, 32, pixel width
- ADDR_BITS, 16, SRAM word-address width
- CH_BITS, 4, width of channel count

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle start pulse, sampled only in IDLE
- cfg_base_addr  in  ADDR_BITS  SRAM address of channel 0 pixel (0,0); latched at start
- cfg_num_ch  in  CH_BITS  number of channels; latched at start
- stall  in  1  downstream backpressure; no new SRAM read while high
- mem_rd_en  out  1  SRAM read strobe (combinational: state==FETCH && !stall)
- mem_addr  out  ADDR_BITS  SRAM read address (registered pointer)
- mem_rdata  in  DATA_BITS  SRAM read data, fixed 1-cycle latency
- pix_valid  out  1  to line-buffer valid input; mem_rd_en delayed 1 cycle
- pix_data  out  DATA_BITS  to line-buffer data input; equals mem_rdata
- win_valid  in  1  window-valid from line buffer
- buf_clr  out  1  one-cycle line-buffer clear; integration inverts it to the buffer's active-low reset
- ch_idx  out  CH_BITS  current channel index
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last channel
- err  out  1  sticky; cleared on the next accepted start

Behaviour:
- Reset values: mem_addr=0, pix_valid=0, buf_clr=0, ch_idx=0, busy=0, done=0, err=0; state=IDLE; pix_cnt=0; win_cnt=0.
- Constants: PIX_PER_CH = WIDTH*HEIGHT (80 at defaults); WIN_PER_CH = (WIDTH-2)*(HEIGHT-2) (48 at defaults).
- IDLE:
  - start=1 and cfg_num_ch!=0: latch the config, mem_addr<=cfg_base_addr, ch_idx<=0, err<=0, go to FETCH.
  - start=1 and cfg_num_ch==0: go directly to DONE (done pulses next cycle, no reads issued).
- FETCH:
  - Each cycle with !stall: mem_rd_en=1, mem_addr<=mem_addr+1, pix_cnt<=pix_cnt+1.
  - When the read with pix_cnt==PIX_PER_CH-1 is issued, go to DRAIN next cycle.
  - Stall cycles issue no read and hold mem_addr and pix_cnt; the read already in flight still produces its pix_valid.
- DRAIN:
  - No reads issued; stall is ignored.
  - Each win_valid increments win_cnt, counting in FETCH and DRAIN alike.
  - When win_cnt==WIN_PER_CH (including the cycle the final win_valid arrives), go to CLR.
- CLR (exactly one cycle):
  - buf_clr=1; pix_cnt<=0; win_cnt<=0.
  - If ch_idx==cfg_num_ch-1, go to DONE.
  - Otherwise ch_idx<=ch_idx+1 and go to FETCH; mem_addr continues, so channel c starts at base + c*PIX_PER_CH.
- DONE (one cycle): done=1, go to IDLE. busy falls in the same cycle that done falls.
- Latency, no stall: first pix_valid 2 cycles after the start pulse; back-to-back pixels thereafter.
- mem_addr is modulo 2^ADDR_BITS and wraps silently.
- win_cnt saturates at WIN_PER_CH.
- err is set on:
  - win_valid while in IDLE, CLR or DONE;
  - win_valid while win_cnt is already WIN_PER_CH.
- Simultaneous events:
  - start while busy is ignored.
  - win_valid in the FETCH cycle that issues the last read is counted.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. No done pulse is produced. The line buffer is reset by the system reset, not by buf_clr.

Decomposition:
- Package conv3_pkg:
  - state enum {IDLE, FETCH, DRAIN, CLR, DONE}
  - functions pix_per_ch(W,H) and win_per_ch(W,H)
  - FILTER_SIZE=3 constant shared with the line buffer
- Single module. The FSM plus three counters (pix_cnt, win_cnt, ch_idx) do not justify a sub-module.

Test Plan:
- 1 channel, base 0x0040, no stall, 48 win_valid pulses driven after the last read:
  - mem_rd_en high 80 consecutive cycles, addresses 0x0040..0x008F;
  - buf_clr for exactly 1 cycle, done 1 cycle later;
  - err=0.
- 2 channels, base 0x0100:
  - addresses 0x0100..0x019F, with a one-cycle buf_clr between the channels;
  - ch_idx 0 then 1;
  - exactly one done.
- stall high for 5 cycles at pix_cnt=20:
  - mem_addr holds, pix_valid drops 1 cycle after stall rises;
  - 80 reads total, total fetch time 85 cycles.
- cfg_num_ch=0 start: no mem_rd_en ever; done 2 cycles after start; busy high 1 cycle.
- win_valid in IDLE, then a 49th win_valid in channel 0: err rises and stays high; next start clears it.
- rst asserted at pix_cnt=30: all outputs at reset values in the same cycle; a fresh start restarts from cfg_base_addr.

Source files
------------

// File: rtl/conv3_pkg.sv
// rtl/conv3_pkg.sv - shared types and geometry helpers for the conv3 sequencer and line buffer
package conv3_pkg;

    localparam int FILTER_SIZE = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        CLR,
        DONE
    } state_t;

    function automatic int pix_per_ch(input int w, input int h);
        return w * h;
    endfunction

    // A 3x3 window is only complete once it fits entirely inside the map.
    function automatic int win_per_ch(input int w, input int h);
        return (w - FILTER_SIZE + 1) * (h - FILTER_SIZE + 1);
    endfunction

endpackage

// File: rtl/conv3_sched_if.sv
// rtl/conv3_sched_if.sv - SRAM read port and line-buffer handshake between sequencer and datapath
interface conv3_sched_if #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 16
);
    logic                 stall;
    logic                 mem_rd_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 pix_valid;
    logic [DATA_BITS-1:0] pix_data;
    logic                 win_valid;
    logic                 buf_clr;

    modport master (
        input  stall, mem_rdata, win_valid,
        output mem_rd_en, mem_addr, pix_valid, pix_data, buf_clr
    );

    modport slave (
        output stall, mem_rdata, win_valid,
        input  mem_rd_en, mem_addr, pix_valid, pix_data, buf_clr
    );
endinterface

// File: rtl/conv3_sched.sv
// rtl/conv3_sched.sv - streams each channel from SRAM into the 3x3 line buffer and counts emitted windows
module conv3_sched
    import conv3_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 10,
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 16,
    parameter int CH_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] cfg_base_addr,
    input  logic [CH_BITS-1:0]   cfg_num_ch,
    output logic [CH_BITS-1:0]   ch_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    conv3_sched_if.master        bus
);

    localparam int PIX      = pix_per_ch(WIDTH, HEIGHT);
    localparam int WIN      = win_per_ch(WIDTH, HEIGHT);
    localparam int PIX_BITS = $clog2(PIX + 1);
    localparam int WIN_BITS = $clog2(WIN + 1);
    localparam logic [PIX_BITS-1:0] PIX_LAST = PIX_BITS'(PIX - 1);
    localparam logic [WIN_BITS-1:0] WIN_MAX  = WIN_BITS'(WIN);

    state_t               state, state_nx;
    logic [PIX_BITS-1:0]  pix_cnt;
    logic [WIN_BITS-1:0]  win_cnt;
    logic [CH_BITS-1:0]   num_ch;
    logic [DATA_BITS-1:0] pix_word;
    logic                 rd_issue;
    logic                 win_full;
    logic                 win_last;
    logic                 win_inc;
    logic                 win_bad;
    logic                 last_ch;

    assign rd_issue      = (state == FETCH) && !bus.stall;
    assign bus.mem_rd_en = rd_issue;
    assign pix_word      = bus.mem_rdata;
    assign bus.pix_data  = pix_word;

    // Window accounting: the final window may land in the same cycle we decide to leave DRAIN.
    assign win_full = (win_cnt == WIN_MAX);
    assign win_last = win_full || (bus.win_valid && (win_cnt == WIN_MAX - WIN_BITS'(1)));
    assign win_inc  = bus.win_valid && ((state == FETCH) || (state == DRAIN)) && !win_full;
    assign win_bad  = bus.win_valid &&
                      ((state == IDLE) || (state == CLR) || (state == DONE) || win_full);
    assign last_ch  = (ch_idx == num_ch - CH_BITS'(1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (cfg_num_ch != '0) ? FETCH : DONE;
            FETCH:   if (rd_issue && (pix_cnt == PIX_LAST)) state_nx = DRAIN;
            DRAIN:   if (win_last) state_nx = CLR;
            CLR:     state_nx = last_ch ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            num_ch        <= '0;
            pix_cnt       <= '0;
            win_cnt       <= '0;
            ch_idx        <= '0;
            bus.mem_addr  <= '0;
            bus.pix_valid <= 1'b0;
            bus.buf_clr   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.pix_valid <= rd_issue;
            bus.buf_clr   <= (state == CLR);
            busy          <= (state != IDLE);
            done          <= (state == DONE);

            if ((state == IDLE) && start) begin
                err <= 1'b0;
                if (cfg_num_ch != '0) begin
                    num_ch       <= cfg_num_ch;
                    bus.mem_addr <= cfg_base_addr;
                    ch_idx       <= '0;
                end
            end

            // Address keeps running across channels, so channel c lands at base + c*PIX.
            if (rd_issue) begin
                bus.mem_addr <= bus.mem_addr + ADDR_BITS'(1);
                pix_cnt      <= pix_cnt + PIX_BITS'(1);
            end

            if (win_inc) win_cnt <= win_cnt + WIN_BITS'(1);

            if (state == CLR) begin
                pix_cnt <= '0;
                win_cnt <= '0;
                if (!last_ch) ch_idx <= ch_idx + CH_BITS'(1);
            end

            if (win_bad) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv3_sched.sv
// tb/tb_conv3_sched.sv - scoreboard bench for conv3_sched
module tb_conv3_sched;

    localparam int PIX = 80;
    localparam int WIN = 48;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  ch;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_base_addr;
    logic [3:0]  cfg_num_ch;
    logic [3:0]  ch_idx;
    logic        busy;
    logic        done;
    logic        err;

    conv3_sched_if #(.DATA_BITS(32), .ADDR_BITS(16)) bus ();

    conv3_sched #(
        .WIDTH(8), .HEIGHT(10), .DATA_BITS(32), .ADDR_BITS(16), .CH_BITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_base_addr(cfg_base_addr),
        .cfg_num_ch(cfg_num_ch),
        .ch_idx(ch_idx),
        .busy(busy),
        .done(done),
        .err(err),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: fixed one-cycle read latency, data tagged with its address.
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= {16'hC0DE, bus.mem_addr};

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        exp_q[$];
    logic [31:0] data_q[$];

    int rd_cnt, pv_cnt, clr_cnt, done_cnt, busy_cnt;
    int first_rd_cyc, last_rd_cyc, first_pv_cyc, last_clr_cyc, done_cyc, start_cyc;
    bit arm_rd, arm_pv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rd_cnt = 0; pv_cnt = 0; clr_cnt = 0; done_cnt = 0; busy_cnt = 0;
        first_rd_cyc = 0; last_rd_cyc = 0; first_pv_cyc = 0; last_clr_cyc = 0; done_cyc = 0;
        arm_rd = 1'b1; arm_pv = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_rd_en) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                if (arm_rd) begin first_rd_cyc = cyc; arm_rd = 1'b0; end
                if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rd_addr", bus.mem_addr, e.addr);
                    chk("rd_ch", ch_idx, e.ch);
                    data_q.push_back({16'hC0DE, e.addr});
                end
            end
            if (bus.pix_valid) begin
                pv_cnt++;
                if (arm_pv) begin first_pv_cyc = cyc; arm_pv = 1'b0; end
                if (data_q.size() == 0) chk("unexpected_pix", 1, 0);
                else chk("pix_data", bus.pix_data, data_q.pop_front());
            end
            if (bus.buf_clr) begin clr_cnt++; last_clr_cyc = cyc; end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic start_cmd(input logic [15:0] base, input logic [3:0] nch);
        exp_t e;
        for (int c = 0; c < int'(nch); c++)
            for (int p = 0; p < PIX; p++) begin
                e.addr = base + 16'(c * PIX + p);
                e.ch   = 4'(c);
                exp_q.push_back(e);
            end
        cfg_base_addr = base;
        cfg_num_ch    = nch;
        start         = 1'b1;
        start_cyc     = cyc;
        tick();
        start         = 1'b0;
    endtask

    task automatic wait_reads(input int n);
        int t = 0;
        while (rd_cnt < n && t < 3000) begin tick(); t++; end
        chk("reads_reached", rd_cnt >= n, 1);
    endtask

    task automatic send_win(input int n);
        for (int i = 0; i < n; i++) begin
            bus.win_valid = 1'b1;
            tick();
        end
        bus.win_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (done_cnt == prev && t < 3000) begin tick(); t++; end
        chk("done_seen", done_cnt, prev + 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_base_addr = '0; cfg_num_ch = '0;
        bus.stall = 1'b0; bus.win_valid = 1'b0;
        clear_stats();
        fork monitor(); join_none
        repeat (3) tick();
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_buf_clr", bus.buf_clr, 0);
        chk("rst_ch_idx", ch_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // one channel, no stall
        clear_stats();
        start_cmd(16'h0040, 4'd1);
        wait_reads(PIX);
        send_win(WIN);
        wait_done(0);
        repeat (3) tick();
        chk("t1_reads", rd_cnt, PIX);
        chk("t1_contig", last_rd_cyc - first_rd_cyc + 1, PIX);
        chk("t1_first_pix_lat", first_pv_cyc - start_cyc, 2);
        chk("t1_pix_cnt", pv_cnt, PIX);
        chk("t1_clr_cycles", clr_cnt, 1);
        chk("t1_done_after_clr", done_cyc - last_clr_cyc, 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_err", err, 0);
        chk("t1_drained", exp_q.size(), 0);

        // two channels
        clear_stats();
        start_cmd(16'h0100, 4'd2);
        wait_reads(PIX);
        send_win(WIN);
        wait_reads(2 * PIX);
        send_win(WIN);
        wait_done(0);
        repeat (3) tick();
        chk("t2_reads", rd_cnt, 2 * PIX);
        chk("t2_clr_cycles", clr_cnt, 2);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_err", err, 0);
        chk("t2_drained", exp_q.size(), 0);

        // five-cycle stall after 20 reads
        clear_stats();
        start_cmd(16'h0200, 4'd1);
        wait_reads(20);
        bus.stall = 1'b1;
        #1;
        chk("t3_stall_rd_en", bus.mem_rd_en, 0);
        chk("t3_inflight_pv", bus.pix_valid, 1);
        chk("t3_hold_addr0", bus.mem_addr, 16'h0214);
        tick();
        chk("t3_pv_drop", bus.pix_valid, 0);
        repeat (3) tick();
        chk("t3_hold_addr4", bus.mem_addr, 16'h0214);
        tick();
        bus.stall = 1'b0;
        wait_reads(PIX);
        chk("t3_fetch_time", last_rd_cyc - first_rd_cyc + 1, PIX + 5);
        send_win(WIN);
        wait_done(0);
        repeat (2) tick();
        chk("t3_reads", rd_cnt, PIX);
        chk("t3_drained", exp_q.size(), 0);

        // zero channels
        clear_stats();
        start_cmd(16'h0300, 4'd0);
        repeat (4) tick();
        chk("t4_no_reads", rd_cnt, 0);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_done_lat", done_cyc - start_cyc, 2);
        chk("t4_busy_cycles", busy_cnt, 1);

        // error paths
        clear_stats();
        send_win(1);
        chk("t5_err_idle", err, 1);
        start_cmd(16'h0400, 4'd1);
        chk("t5_err_cleared", err, 0);
        wait_reads(PIX);
        send_win(WIN + 1);
        chk("t5_err_extra_win", err, 1);
        wait_done(0);
        repeat (3) tick();
        chk("t5_err_sticky", err, 1);
        chk("t5_clr_cycles", clr_cnt, 1);

        // reset in the middle of a fetch
        clear_stats();
        start_cmd(16'h0600, 4'd1);
        chk("t6_err_cleared", err, 0);
        wait_reads(30);
        rst = 1'b1;
        #1;
        chk("t6_mem_addr", bus.mem_addr, 0);
        chk("t6_rd_en", bus.mem_rd_en, 0);
        chk("t6_pix_valid", bus.pix_valid, 0);
        chk("t6_buf_clr", bus.buf_clr, 0);
        chk("t6_ch_idx", ch_idx, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        exp_q.delete();
        data_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_no_done", done_cnt, 0);
        clear_stats();
        start_cmd(16'h0600, 4'd1);
        wait_reads(PIX);
        send_win(WIN);
        wait_done(0);
        repeat (2) tick();
        chk("t6_restart_reads", rd_cnt, PIX);
        chk("t6_restart_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
